// File: rtl/stream_demux_3_pkg.sv
// Shared constants and types for the three-way stream demultiplexer.
// Select encoding matches the three-way select mux: code 3 aliases to C.
package stream_demux_3_pkg;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;

    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_cnt_e;

    // One-hot {c, b, a}; any code other than A or B lands on C.
    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        oh = 3'b000;
        unique case (sel)
            SEL_A:   oh = 3'b001;
            SEL_B:   oh = 3'b010;
            default: oh = 3'b100;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/stream_demux_3_fifo2.sv
// Two-entry per-channel FIFO for the stream demux.
// No pass-through: a full FIFO refuses a push even while it is popped.
module demux_fifo2
    import stream_demux_3_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [DATA_W-1:0] last;
    logic              wptr;
    logic              rptr;
    fifo_cnt_e         cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            last <= '0;
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= EMPTY;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= ~wptr;
            end
            if (pop) begin
                last <= mem[rptr];
                rptr <= ~rptr;
            end
            unique case ({push, pop})
                2'b10:   cnt <= (cnt == EMPTY) ? ONE : FULL;
                2'b01:   cnt <= (cnt == FULL) ? ONE : EMPTY;
                default: cnt <= cnt;
            endcase
        end
    end

    assign full       = (cnt == FULL);
    assign head_valid = (cnt != EMPTY);
    // Once drained, keep showing the word most recently handed out.
    assign head_data  = head_valid ? mem[rptr] : last;

endmodule

// File: rtl/stream_demux_3.sv
// 1-to-3 stream demultiplexer with an independent 2-deep FIFO per channel.
// in_ready depends only on the selected FIFO's fill, never on consumer ready.
module stream_demux_3
    import stream_demux_3_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_select,
    output logic              out_a_valid,
    input  logic              out_a_ready,
    output logic [DATA_W-1:0] out_a_data,
    output logic              out_b_valid,
    input  logic              out_b_ready,
    output logic [DATA_W-1:0] out_b_data,
    output logic              out_c_valid,
    input  logic              out_c_ready,
    output logic [DATA_W-1:0] out_c_data,
    output logic              busy
);

    logic [2:0] sel_oh;
    logic [2:0] full;
    logic [2:0] push;
    logic       accept;

    assign sel_oh   = sel_onehot(in_select);
    assign in_ready = |(sel_oh & ~full);
    assign accept   = in_valid & in_ready;
    assign push     = sel_oh & {3{accept}};
    assign busy     = out_a_valid | out_b_valid | out_c_valid;

    demux_fifo2 #(.DATA_W(DATA_W)) u_fifo_a (
        .clk        (clk),
        .arst_n     (arst_n),
        .push       (push[0]),
        .push_data  (in_data),
        .full       (full[0]),
        .pop        (out_a_valid & out_a_ready),
        .head_valid (out_a_valid),
        .head_data  (out_a_data)
    );

    demux_fifo2 #(.DATA_W(DATA_W)) u_fifo_b (
        .clk        (clk),
        .arst_n     (arst_n),
        .push       (push[1]),
        .push_data  (in_data),
        .full       (full[1]),
        .pop        (out_b_valid & out_b_ready),
        .head_valid (out_b_valid),
        .head_data  (out_b_data)
    );

    demux_fifo2 #(.DATA_W(DATA_W)) u_fifo_c (
        .clk        (clk),
        .arst_n     (arst_n),
        .push       (push[2]),
        .push_data  (in_data),
        .full       (full[2]),
        .pop        (out_c_valid & out_c_ready),
        .head_valid (out_c_valid),
        .head_data  (out_c_data)
    );

    // A stalled producer must hold its word and destination.
    a_hold_stable : assert property (
        @(posedge clk) disable iff (!arst_n)
        (in_valid && !in_ready) |=>
            (!in_valid || ($stable(in_data) && $stable(in_select)))
    );

endmodule

// File: doc/stream_demux_3.md
Name: stream_demux_3

Overview:
Stream-side counterpart of the three-way select mux: a 1-to-3 demultiplexer that steers each accepted input word to channel A, B or C. The select encoding is identical to the mux: 0 selects A, 1 selects B, 2 or 3 selects C. Each channel has its own 2-entry FIFO with a valid/ready handshake, so one stalled consumer does not block traffic to the other two. It sits between a single producer (e.g. a decode/issue stage) and three independent consumers (e.g. ALU, memory and branch paths).

Parameters:
DATA_W, 16, width of the data word in bits.

Ports:
clk  input  1  system clock; all state updates on rising edge.
arst_n  input  1  asynchronous reset, active-low.
in_valid  input  1  producer has a word on in_data.
in_ready  output  1  demux accepts the word this cycle.
in_data  input  DATA_W  input word.
in_select  input  2  destination: 0=A, 1=B, 2 or 3=C.
out_a_valid / out_b_valid / out_c_valid  output  1 each  channel head entry is valid.
out_a_ready / out_b_ready / out_c_ready  input  1 each  consumer takes the head entry.
out_a_data / out_b_data / out_c_data  output  DATA_W each  channel head data.
busy  output  1  at least one channel FIFO is non-empty.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, arst_n).
- Reset, asynchronous on arst_n=0:
  - All FIFO pointers and counts go to 0.
  - All out_*_valid = 0, all out_*_data = 0, busy = 0.
  - in_ready reflects the empty FIFOs, i.e. 1 once reset is released.
- in_ready is combinational:
  - It equals "FIFO selected by in_select is not full".
  - It does not depend on any out_*_ready, so there is no combinational path from consumer to producer.
- Accept (push): in_valid && in_ready at a rising edge writes in_data into the selected FIFO.
  - The producer holds in_data and in_select stable while in_valid=1 and in_ready=0.
  - A change while stalled is a protocol violation; behaviour is undefined and assertions flag it.
- Pop: out_x_valid && out_x_ready at a rising edge removes the channel head.
- Latency:
  - A word accepted at edge N appears on out_x_data with out_x_valid=1 after edge N (1 cycle), provided the channel was empty.
  - Otherwise it appears behind the older entries.
- Ordering: FIFO order is preserved within each channel. No ordering is guaranteed across channels.
- Per-channel FIFO:
  - Depth 2.
  - Count states EMPTY(0), ONE(1), FULL(2).
  - Transitions:
    - push only: count+1.
    - pop only: count-1.
    - push and pop in the same cycle: count unchanged, head advances, new tail written.
  - Push while FULL cannot occur because in_ready=0.
  - Pop while EMPTY cannot occur because out_x_valid=0.
  - Simultaneous push and pop on a FULL channel is not allowed: in_ready is already 0. There is no pass-through.
  - Read and write pointers are 1 bit each and wrap 1->0.
- out_x_data:
  - Driven from the storage entry at the read pointer.
  - When empty it holds the last popped value; consumers must ignore it while valid=0.
- Throughput:
  - A single channel sustains 1 word/cycle when its consumer keeps ready=1.
  - Backpressure on one channel stalls the producer only when that channel is selected and full.
- busy = OR of the three channel non-empty flags, registered-equivalent (derived from counts).
- Reset mid-operation: all buffered words are discarded immediately; no partial output.

Decomposition:
- Shared package constants:
  - SEL_A=2'd0, SEL_B=2'd1, SEL_C=2'd2. Code 3 aliases to C, matching the mux.
  - FIFO_DEPTH=2.
- Sub-module demux_fifo2, instantiated 3 times.
  - Parameter: DATA_W.
  - Ports: clk, arst_n, push, push_data, full, pop, head_valid, head_data.
- Top level: select decode, in_ready mux, busy OR.

Test Plan:
1. Reset check: assert arst_n=0 mid-run with words buffered -> all out_*_valid=0 and busy=0 immediately; after release, in_ready=1.
2. Single word: in_select=1, in_data=16'h1234 with ready high on all consumers -> out_b_valid=1 with 16'h1234 the next cycle; A and C stay invalid.
3. Backpressure on C: out_c_ready=0, push 3 words (0xA, 0xB, 0xC) with in_select=2 -> first two accepted; in_ready=0 for the third. Raise out_c_ready -> 0xA, 0xB, 0xC emerge in order, one per cycle.
4. Channel independence: C full and stalled, push in_select=0 data 0x55 -> accepted (in_ready=1); out_a_data=0x55 the next cycle.
5. Alias code: in_select=3, data 0x77 -> appears on C only.
6. Streaming: 100 random words, random selects and random consumer ready -> per-channel scoreboard matches in order; no loss or duplication; busy=0 after drain.
